// File: rtl/cache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cache_write_buffer
// Description : Posted-write buffer between the set-associative cache and RAM.
//               Circular FIFO of {addr, data} entries drained to RAM one write
//               every two cycles, with newest-entry forwarding to read-miss
//               lookups. Optional macro WB_COALESCE_EN merges a push into a
//               live entry with the same address.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_req,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       lk_addr,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data,
    input  logic                    ram_busy,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_wdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [PTR_W-1:0]  w_slot_idx [DEPTH];
    logic              w_live     [DEPTH];
    logic              w_full;
    logic              w_accept;
    logic              w_coal;
    logic [PTR_W-1:0]  w_coal_idx;
    logic              w_coal_wr;
    logic              w_alloc;
    logic              w_issue;
    logic              w_pop;
    logic [DATA_W-1:0] w_issue_data;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign wr_ready  = !w_full;
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign w_accept  = wr_req && wr_ready;
    assign w_coal_wr = w_accept && w_coal;
    assign w_alloc   = w_accept && !w_coal;

    // Slot k is the k-th oldest entry counted from the head.
    genvar gk;
    generate
        for (gk = 0; gk < DEPTH; gk++) begin : g_slot
            assign w_slot_idx[gk] = r_head + PTR_W'(gk);
            assign w_live[gk]     = (CNT_W'(gk) < r_count);
        end
    endgenerate

    // Forwarding: scan oldest to newest so the newest live match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_live[k] && (r_addr[w_slot_idx[k]] == lk_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_slot_idx[k]];
            end
        end
    end

`ifdef WB_COALESCE_EN
    // Coalesce target: newest live match, excluding the head while it is being written.
    always_comb begin
        w_coal     = 1'b0;
        w_coal_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_live[k] && (r_addr[w_slot_idx[k]] == wr_addr) &&
                !((k == 0) && (r_state == S_WRITE))) begin
                w_coal     = 1'b1;
                w_coal_idx = w_slot_idx[k];
            end
        end
    end
`else
    assign w_coal     = 1'b0;
    assign w_coal_idx = '0;
`endif

    // A coalesce into the head on the issue edge must reach RAM with the new data.
    assign w_issue_data = (w_coal_wr && (w_coal_idx == r_head)) ? wr_data : r_data[r_head];

    // Drain FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Drain FSM next-state: a WRITE always completes and is followed by a recovery GAP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if ((r_count != '0) && !ram_busy) w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_GAP;
            S_GAP:   w_next_state = ((r_count != '0) && !ram_busy) ? S_WRITE : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Drain FSM outputs: issue loads the RAM port, pop retires the head at WRITE exit.
    always_comb begin
        w_issue = (w_next_state == S_WRITE);
        w_pop   = (r_state == S_WRITE);
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_addr[k] <= '0;
                r_data[k] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_addr[r_tail] <= wr_addr;
                r_data[r_tail] <= wr_data;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_coal_wr) begin
                r_data[w_coal_idx] <= wr_data;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered RAM write port; reset drops the strobe without waiting for an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_we <= w_issue;
            if (w_issue) begin
                ram_addr  <= r_addr[r_head];
                ram_wdata <= w_issue_data;
            end
        end
    end

endmodule
`default_nettype wire
